// File: rtl/axis_planar_interleaver_pkg.sv
// Shared types and helpers for the planar-to-interleaved pixel packer.
package axis_pix_pkg;

  typedef enum logic {
    ST_LOAD   = 1'b0,
    ST_STREAM = 1'b1
  } state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) begin
      r++;
    end
    return r;
  endfunction

  // Index counters need at least one bit even when the range is a single value.
  function automatic int idx_w(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

  // Bit offset of channel ch inside a packed pixel; channel 0 sits in the MSBs.
  function automatic int ch_lsb(input int ch, input int num_ch, input int data_w);
    return (num_ch - 1 - ch) * data_w;
  endfunction

endpackage

// File: rtl/axis_planar_interleaver_plane_buffer.sv
// Single-plane sample store: synchronous write, combinational read.
module plane_buffer
  import axis_pix_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [idx_w(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]        wdata,
  input  logic [idx_w(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]        rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Contents deliberately have no reset; every location is rewritten before use.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/axis_planar_interleaver.sv
// Planar AXI-Stream image to interleaved pixel stream; the last plane is merged on the fly.
//   state     | meaning
//   ST_LOAD   | buffering planes 0..NUM_CH-2, input always ready
//   ST_STREAM | last plane arriving, each sample emits one full pixel
module axis_planar_interleaver
  import axis_pix_pkg::*;
#(
  parameter int NUM_CH     = 3,
  parameter int DATA_W     = 8,
  parameter int IMG_PIXELS = 1024,
  parameter int CNT_W      = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     s_tvalid,
  input  logic [DATA_W-1:0]        s_tdata,
  input  logic                     s_tlast,
  output logic                     s_tready,
  output logic                     m_tvalid,
  output logic [NUM_CH*DATA_W-1:0] m_tdata,
  output logic                     m_tlast,
  output logic                     m_tuser,
  input  logic                     m_tready,
  output logic                     frame_err,
  output logic [CNT_W-1:0]         frame_cnt
);

  localparam int OUT_W = NUM_CH * DATA_W;
  localparam int CH_W  = idx_w(NUM_CH);
  localparam int PIX_W = idx_w(IMG_PIXELS);

  localparam logic [CH_W-1:0]  CH_PRELAST = CH_W'(NUM_CH - 2);
  localparam logic [PIX_W-1:0] PIX_LAST   = PIX_W'(IMG_PIXELS - 1);
  // A single-channel image has nothing to buffer, so it never leaves ST_STREAM.
  localparam state_e ST_START = (NUM_CH == 1) ? ST_STREAM : ST_LOAD;

  state_e             state_q, state_d;
  logic [CH_W-1:0]    ch_idx_q, ch_idx_d;
  logic [PIX_W-1:0]   pix_idx_q, pix_idx_d;
  logic               m_tvalid_q, m_tvalid_d;
  logic [OUT_W-1:0]   m_tdata_q, m_tdata_d;
  logic               m_tlast_q, m_tlast_d;
  logic               m_tuser_q, m_tuser_d;
  logic               frame_err_q, frame_err_d;
  logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;

  logic               in_stream;
  logic               s_tready_int;
  logic               accept;
  logic               pix_end;
  logic               final_beat;
  logic               early_last;
  logic               load_wr;
  logic [DATA_W-1:0]  plane_rd [NUM_CH];
  logic [OUT_W-1:0]   pix_word;

  assign in_stream    = (state_q == ST_STREAM);
  assign s_tready_int = !in_stream || !m_tvalid_q || m_tready;
  assign accept       = s_tvalid && s_tready_int;
  assign pix_end      = (pix_idx_q == PIX_LAST);
  assign final_beat   = in_stream && pix_end;
  assign early_last   = accept && s_tlast && !final_beat;
  assign load_wr      = accept && !s_tlast && !in_stream;

  for (genvar g = 0; g < NUM_CH - 1; g++) begin : g_plane
    logic we_g;
    assign we_g = load_wr && (ch_idx_q == CH_W'(g));

    plane_buffer #(
      .DEPTH (IMG_PIXELS),
      .WIDTH (DATA_W)
    ) u_plane (
      .clk   (clk),
      .we    (we_g),
      .waddr (pix_idx_q),
      .wdata (s_tdata),
      .raddr (pix_idx_q),
      .rdata (plane_rd[g])
    );
  end

  assign plane_rd[NUM_CH-1] = s_tdata;

  always_comb begin
    pix_word = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      pix_word[ch_lsb(c, NUM_CH, DATA_W) +: DATA_W] = plane_rd[c];
    end
  end

  always_comb begin
    state_d     = state_q;
    ch_idx_d    = ch_idx_q;
    pix_idx_d   = pix_idx_q;
    m_tvalid_d  = m_tvalid_q;
    m_tdata_d   = m_tdata_q;
    m_tlast_d   = m_tlast_q;
    m_tuser_d   = m_tuser_q;
    frame_err_d = 1'b0;
    frame_cnt_d = frame_cnt_q;

    if (m_tvalid_q && m_tready) begin
      m_tvalid_d = 1'b0;
      m_tlast_d  = 1'b0;
      m_tuser_d  = 1'b0;
    end

    if (early_last) begin
      frame_err_d = 1'b1;
      ch_idx_d    = '0;
      pix_idx_d   = '0;
      state_d     = ST_START;
    end else if (accept) begin
      if (in_stream) begin
        m_tvalid_d = 1'b1;
        m_tdata_d  = pix_word;
        m_tuser_d  = (pix_idx_q == '0);
        m_tlast_d  = pix_end;
      end
      if (pix_end) begin
        pix_idx_d = '0;
        if (in_stream) begin
          ch_idx_d    = '0;
          state_d     = ST_START;
          frame_cnt_d = frame_cnt_q + CNT_W'(1);
          frame_err_d = !s_tlast;
        end else begin
          ch_idx_d = ch_idx_q + CH_W'(1);
          if (ch_idx_q == CH_PRELAST) begin
            state_d = ST_STREAM;
          end
        end
      end else begin
        pix_idx_d = pix_idx_q + PIX_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_START;
      ch_idx_q    <= '0;
      pix_idx_q   <= '0;
      m_tvalid_q  <= 1'b0;
      m_tdata_q   <= '0;
      m_tlast_q   <= 1'b0;
      m_tuser_q   <= 1'b0;
      frame_err_q <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      ch_idx_q    <= ch_idx_d;
      pix_idx_q   <= pix_idx_d;
      m_tvalid_q  <= m_tvalid_d;
      m_tdata_q   <= m_tdata_d;
      m_tlast_q   <= m_tlast_d;
      m_tuser_q   <= m_tuser_d;
      frame_err_q <= frame_err_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign s_tready  = s_tready_int;
  assign m_tvalid  = m_tvalid_q;
  assign m_tdata   = m_tdata_q;
  assign m_tlast   = m_tlast_q;
  assign m_tuser   = m_tuser_q;
  assign frame_err = frame_err_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_axis_planar_interleaver.sv
// Scoreboard bench for axis_planar_interleaver: directed image cases plus random frames.
module tb_axis_planar_interleaver;

  localparam int NUM_CH     = 3;
  localparam int DATA_W     = 8;
  localparam int IMG_PIXELS = 4;
  localparam int CNT_W      = 16;
  localparam int OUT_W      = NUM_CH * DATA_W;
  localparam int TOTAL      = NUM_CH * IMG_PIXELS;
  localparam int CLK_P      = 10;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              s_tvalid = 1'b0;
  logic [DATA_W-1:0] s_tdata = '0;
  logic              s_tlast = 1'b0;
  logic              s_tready;
  logic              m_tvalid;
  logic [OUT_W-1:0]  m_tdata;
  logic              m_tlast;
  logic              m_tuser;
  logic              m_tready = 1'b1;
  logic              frame_err;
  logic [CNT_W-1:0]  frame_cnt;

  axis_planar_interleaver #(
    .NUM_CH     (NUM_CH),
    .DATA_W     (DATA_W),
    .IMG_PIXELS (IMG_PIXELS),
    .CNT_W      (CNT_W)
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_tvalid  (s_tvalid),
    .s_tdata   (s_tdata),
    .s_tlast   (s_tlast),
    .s_tready  (s_tready),
    .m_tvalid  (m_tvalid),
    .m_tdata   (m_tdata),
    .m_tlast   (m_tlast),
    .m_tuser   (m_tuser),
    .m_tready  (m_tready),
    .frame_err (frame_err),
    .frame_cnt (frame_cnt)
  );

  always #(CLK_P/2) clk = ~clk;

  typedef struct packed {
    logic [OUT_W-1:0] data;
    logic             last;
    logic             user;
  } beat_t;

  beat_t exp_q[$];
  time   err_q[$];
  int    vectors = 0;
  int    miscompares = 0;

  // Reference: samples of the current frame in arrival order, position in frame, frames completed.
  logic [DATA_W-1:0] model_buf [TOTAL];
  int                model_idx = 0;
  int                model_frames = 0;
  int                tready_mode = 0;
  int                tready_phase = 0;

  logic              prev_stall = 1'b0;
  logic [OUT_W-1:0]  prev_data = '0;
  logic              prev_last = 1'b0;
  logic              prev_user = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: condition not reached within cycle budget at %0t", name, $time);
  endtask

  task automatic model_accept(input logic [DATA_W-1:0] d, input logic l);
    bit    is_final;
    int    p;
    beat_t b;
    is_final = (model_idx == TOTAL - 1);
    if (l && !is_final) begin
      err_q.push_back($time + CLK_P);
      model_idx = 0;
      return;
    end
    model_buf[model_idx] = d;
    if (model_idx >= (NUM_CH - 1) * IMG_PIXELS) begin
      p = model_idx - (NUM_CH - 1) * IMG_PIXELS;
      b.data = '0;
      for (int c = 0; c < NUM_CH; c++) begin
        b.data = (b.data << DATA_W) | OUT_W'(model_buf[c * IMG_PIXELS + p]);
      end
      b.last = (p == IMG_PIXELS - 1);
      b.user = (p == 0);
      exp_q.push_back(b);
    end
    if (is_final) begin
      if (!l) err_q.push_back($time + CLK_P);
      model_idx = 0;
      model_frames++;
    end else begin
      model_idx++;
    end
  endtask

  task automatic send(input logic [DATA_W-1:0] d, input logic l);
    int   n;
    bit   ok;
    logic exp_rdy;
    n  = 0;
    ok = 0;
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tlast  = l;
    while (!ok) begin
      @(negedge clk);
      exp_rdy = (model_idx < (NUM_CH - 1) * IMG_PIXELS) ? 1'b1 : !(m_tvalid && !m_tready);
      check("s_tready", 64'(s_tready), 64'(exp_rdy));
      if (s_tready) ok = 1;
      else if (++n > 200) begin
        fail_now("send_timeout");
        break;
      end
    end
    if (ok) model_accept(d, l);
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input int base, input bit drop_last);
    for (int i = 0; i < TOTAL; i++) begin
      send(DATA_W'(base + i + 1), (i == TOTAL - 1) && !drop_last);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || err_q.size() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0 || err_q.size() != 0) fail_now("drain_timeout");
    idle(3);
    check("frame_cnt", 64'(frame_cnt), 64'(CNT_W'(model_frames)));
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n    = 1'b0;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    exp_q.delete();
    err_q.delete();
    model_idx    = 0;
    model_frames = 0;
    @(negedge clk);
    check("rst_m_tvalid", 64'(m_tvalid), 64'd0);
    check("rst_m_tlast", 64'(m_tlast), 64'd0);
    check("rst_m_tuser", 64'(m_tuser), 64'd0);
    check("rst_m_tdata", 64'(m_tdata), 64'd0);
    check("rst_frame_err", 64'(frame_err), 64'd0);
    check("rst_frame_cnt", 64'(frame_cnt), 64'd0);
    check("rst_s_tready", 64'(s_tready), 64'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (tready_mode)
        0: m_tready = 1'b1;
        1: begin
          m_tready = (tready_phase % 3 == 0);
          tready_phase++;
        end
        default: m_tready = ($urandom_range(0, 2) != 0);
      endcase
    end
  end

  initial begin
    beat_t e;
    logic  exp_err;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        exp_err = 1'b0;
        if (err_q.size() > 0 && err_q[0] == $time) begin
          exp_err = 1'b1;
          void'(err_q.pop_front());
        end
        check("frame_err", 64'(frame_err), 64'(exp_err));
        if (prev_stall) begin
          check("hold_valid", 64'(m_tvalid), 64'd1);
          check("hold_data", 64'(m_tdata), 64'(prev_data));
          check("hold_last", 64'(m_tlast), 64'(prev_last));
          check("hold_user", 64'(m_tuser), 64'(prev_user));
        end
        if (m_tvalid && m_tready) begin
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_beat: got 0x%0h, expected no beat at %0t", m_tdata, $time);
          end else begin
            e = exp_q.pop_front();
            check("m_tdata", 64'(m_tdata), 64'(e.data));
            check("m_tlast", 64'(m_tlast), 64'(e.last));
            check("m_tuser", 64'(m_tuser), 64'(e.user));
          end
        end
        prev_stall = m_tvalid && !m_tready;
        prev_data  = m_tdata;
        prev_last  = m_tlast;
        prev_user  = m_tuser;
      end
    end
  end

  initial begin
    int kind;
    int cut;
    do_reset();

    // Plain frame 01..0C at full throughput.
    tready_mode = 0;
    send_frame(0, 0);
    drain();

    // Same frame with a 1,0,0 ready pattern.
    tready_mode  = 1;
    tready_phase = 0;
    send_frame(0, 0);
    drain();

    // Two frames back to back under backpressure.
    send_frame(8'h20, 0);
    send_frame(8'h40, 0);
    drain();

    // Early s_tlast on the second sample of plane 1, then a clean frame.
    tready_mode = 0;
    for (int i = 0; i < IMG_PIXELS + 1; i++) send(DATA_W'(i + 1), 1'b0);
    send(DATA_W'(IMG_PIXELS + 2), 1'b1);
    send_frame(8'h60, 0);
    drain();

    // Missing s_tlast on the final sample.
    send_frame(8'h80, 1);
    drain();

    // Reset while the last plane is streaming with stalls, then a clean frame.
    tready_mode = 2;
    for (int i = 0; i < TOTAL - 2; i++) send(DATA_W'(8'hA0 + i), 1'b0);
    do_reset();
    send_frame(8'hB0, 0);
    drain();

    // Random frames with random gaps, backpressure and framing faults.
    for (int f = 0; f < 30; f++) begin
      kind = $urandom_range(0, 9);
      cut  = $urandom_range(0, TOTAL - 2);
      for (int i = 0; i < TOTAL; i++) begin
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        if (kind == 0 && i == cut) begin
          send(DATA_W'($urandom), 1'b1);
          break;
        end
        send(DATA_W'($urandom), (i == TOTAL - 1) && (kind != 1));
      end
    end
    drain();

    check("end_exp_q_empty", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
